demod_top: RTL and testbench
============================

DEMOD_TOP -- requirements
Module: demod_top

Interface
REQ-001 The module SHALL have the ports listed in REQ-002 to REQ-008 and no other ports.
REQ-002 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 N_Rst  input  1  reset; asynchronous and active-low.
REQ-004 In_Mod_Data  input  1  received DCSK chip (1 = +1, 0 = -1).
REQ-005 Valid  input  1  chip qualifier; In_Mod_Data is sampled only when Valid=1.
REQ-006 Spread_Factor_Sel  input  2  spreading factor beta: 00=2, 01=4, 10=8, 11=16.
REQ-007 Out_Data  output  32  last fully demodulated 32-bit word.
REQ-008 Valid_Data  output  1  one-cycle strobe marking a new Out_Data word.

Function
REQ-009 Frame format: one data bit = 2*beta consecutive valid chips.
- The first beta chips are the reference chips.
- The next beta chips are the information chips.
REQ-010 The block SHALL implement a state machine with three states:
- IDLE: no frame in progress.
- REF: collecting reference chips; entered on the first valid chip, which SHALL be taken as reference chip 0.
- INFO: collecting information chips; entered after beta reference chips.
REQ-011 In REF, the block SHALL store each reference chip k (k = 0..beta-1) in a 16-bit reference register.
REQ-012 In INFO, the block SHALL compare information chip k with reference chip k and increment a 5-bit match counter on equality.
REQ-013 Bit decision at the last information chip: bit = 1 if 2*matches > beta, else 0.
- A tie (matches = beta/2) SHALL decide 0.
- All chips matching SHALL decide 1; no chips matching SHALL decide 0.
REQ-014 After the last information chip, the state SHALL return to REF, so back-to-back frames need no gap cycles.
REQ-015 Decided bits SHALL be packed LSB-first: the first bit of a word goes to bit 0, the 32nd bit to bit 31.
REQ-016 A word assembly register SHALL hold the bits; a 5-bit bit counter SHALL wrap from 31 to 0.
REQ-017 Latency: on the clock edge following the edge that samples the last information chip of the 32nd frame:
- Out_Data SHALL load the complete word.
- Valid_Data SHALL be 1 for exactly one cycle.
REQ-018 Out_Data SHALL hold its value until the next completed word.
REQ-019 Spread_Factor_Sel SHALL be latched on the transition IDLE->REF at the start of a word and held for the rest of that word.
- Changes at other times SHALL take effect at the next word start.
REQ-020 If Valid=0 in a cycle while in REF or INFO, the block SHALL go to IDLE and discard the partial frame, the match count and the partially assembled word.
- Out_Data SHALL be unaffected.
- The next valid chip SHALL start a new word at bit 0.
REQ-021 While in IDLE, Valid=0 SHALL leave all state unchanged and Valid_Data SHALL stay 0.
REQ-022 Simultaneous events: a word completion in the same cycle that Valid drops SHALL still emit the word.
- Completion is decided on the last chip's sampling edge, before the Valid check of the next cycle.

Reset
REQ-023 When N_Rst=0, the block SHALL asynchronously set:
- Out_Data = 32'h0 and Valid_Data = 0;
- state = IDLE;
- all counters, the reference register, the word register and the latched beta to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame, with no Valid_Data strobe.
REQ-025 After N_Rst deasserts, the first rising Clk edge with Valid=1 SHALL sample reference chip 0.

Verification
REQ-026 Valid=0 for 1000 cycles with random In_Mod_Data -> Valid_Data stays 0 and Out_Data stays 0.
REQ-027 beta=16, 32 noise-free frames encoding 32'hA5A5_3C3C -> after 1024 valid chips, Valid_Data pulses once and Out_Data=32'hA5A5_3C3C.
REQ-028 Each of beta=8, 4 and 2 with word 32'hDEAD_BEEF, words sent back-to-back -> one pulse per word, at chip counts 512/256/128, and every Out_Data=32'hDEADBEEF.
REQ-029 beta=4 with info chips matching on exactly 2 of 4 chips (tie) -> bit 0; with 3 of 4 matching -> bit 1.
REQ-030 Valid dropped for 1 cycle after 10 frames at beta=16, then a full 32-frame word 32'h1234_5678 -> one pulse only, Out_Data=32'h12345678.
REQ-031 N_Rst asserted mid-word at beta=2, then a full word 32'hFFFF_0000 -> Out_Data=0 during reset, then 32'hFFFF0000 after 128 valid chips.

Source files
------------

// File: rtl/demod_top.sv
// DCSK chip demodulator: correlates beta information chips against beta reference
// chips per bit, and packs decided bits LSB-first into 32-bit words.
module demod_top (
  input  logic        Clk,
  input  logic        N_Rst,
  input  logic        In_Mod_Data,
  input  logic        Valid,
  input  logic [1:0]  Spread_Factor_Sel,
  output logic [31:0] Out_Data,
  output logic        Valid_Data
);

  typedef enum logic [1:0] {IDLE, REF, INFO} state_t;

  state_t      state;
  logic [1:0]  sf_sel;
  logic [3:0]  chip_cnt;
  logic [15:0] ref_reg;
  logic [4:0]  match_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] word_reg;
  logic [1:0]  vld_pipe;

  logic [4:0]  beta;
  logic [3:0]  last_chip;
  logic        chip_match;
  logic [4:0]  match_next;
  logic        bit_dec;

  always_comb begin
    beta       = 5'd2 << sf_sel;
    last_chip  = 4'(beta - 5'd1);
    chip_match = (In_Mod_Data == ref_reg[chip_cnt]);
    match_next = match_cnt + {4'd0, chip_match};
    // strict majority: a tie decides 0
    bit_dec    = ({match_next, 1'b0} > {1'b0, beta});
  end

  assign Valid_Data = vld_pipe[1];

  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state     <= IDLE;
      sf_sel    <= 2'd0;
      chip_cnt  <= 4'd0;
      ref_reg   <= 16'd0;
      match_cnt <= 5'd0;
      bit_cnt   <= 5'd0;
      word_reg  <= 32'd0;
      vld_pipe  <= 2'd0;
      Out_Data  <= 32'd0;
    end else begin
      // word completion is flagged on the last chip's edge and published one edge later,
      // so a Valid drop right after completion still emits the word
      vld_pipe <= {vld_pipe[0], 1'b0};
      if (vld_pipe[0]) Out_Data <= word_reg;

      case (state)
        IDLE: begin
          if (Valid) begin
            sf_sel    <= Spread_Factor_Sel;
            ref_reg   <= {15'd0, In_Mod_Data};
            chip_cnt  <= 4'd1;
            match_cnt <= 5'd0;
            bit_cnt   <= 5'd0;
            word_reg  <= 32'd0;
            state     <= REF;
          end
        end
        REF: begin
          if (!Valid) begin
            state     <= IDLE;
            chip_cnt  <= 4'd0;
            match_cnt <= 5'd0;
            bit_cnt   <= 5'd0;
            word_reg  <= 32'd0;
          end else begin
            ref_reg[chip_cnt] <= In_Mod_Data;
            if (chip_cnt == last_chip) begin
              chip_cnt  <= 4'd0;
              match_cnt <= 5'd0;
              state     <= INFO;
            end else begin
              chip_cnt <= chip_cnt + 4'd1;
            end
          end
        end
        INFO: begin
          if (!Valid) begin
            state     <= IDLE;
            chip_cnt  <= 4'd0;
            match_cnt <= 5'd0;
            bit_cnt   <= 5'd0;
            word_reg  <= 32'd0;
          end else if (chip_cnt == last_chip) begin
            word_reg[bit_cnt] <= bit_dec;
            bit_cnt   <= bit_cnt + 5'd1;
            match_cnt <= 5'd0;
            chip_cnt  <= 4'd0;
            state     <= REF;
            if (bit_cnt == 5'd31) vld_pipe[0] <= 1'b1;
          end else begin
            match_cnt <= match_next;
            chip_cnt  <= chip_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_top.sv
// Directed bench for demod_top: builds DCSK frames with a chosen number of matching
// info chips and checks emitted words and the chip count at each strobe.
module tb_demod_top;

  logic        Clk;
  logic        N_Rst;
  logic        In_Mod_Data;
  logic        Valid;
  logic [1:0]  Spread_Factor_Sel;
  logic [31:0] Out_Data;
  logic        Valid_Data;

  int vectors = 0;
  int miscompares = 0;

  int vchips = 0;
  int prev_vchips = 0;
  int base = 0;
  int pos_q[$];
  logic [31:0] word_q[$];

  demod_top dut (
    .Clk(Clk), .N_Rst(N_Rst), .In_Mod_Data(In_Mod_Data), .Valid(Valid),
    .Spread_Factor_Sel(Spread_Factor_Sel), .Out_Data(Out_Data), .Valid_Data(Valid_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // count chips sampled by the DUT; prev_vchips = chips sampled before the latest edge
  always @(posedge Clk) begin
    prev_vchips = vchips;
    if (N_Rst && Valid) vchips = vchips + 1;
  end

  always @(negedge Clk) begin
    if (Valid_Data) begin
      pos_q.push_back(prev_vchips - base);
      word_q.push_back(Out_Data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_chip(input logic b);
    @(negedge Clk);
    Valid = 1'b1;
    In_Mod_Data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Valid = 1'b0;
      In_Mod_Data = 1'($urandom);
    end
  endtask

  task automatic send_frame(input int beta, input int nmatch);
    logic r [16];
    for (int k = 0; k < beta; k++) begin
      r[k] = 1'($urandom);
      send_chip(r[k]);
    end
    for (int k = 0; k < beta; k++) send_chip(k < nmatch ? r[k] : ~r[k]);
  endtask

  task automatic send_word(input int beta, input logic [31:0] w);
    for (int i = 0; i < 32; i++) send_frame(beta, w[i] ? beta : 0);
  endtask

  task automatic clear_log();
    pos_q.delete();
    word_q.delete();
    base = vchips;
  endtask

  initial begin
    N_Rst = 1'b0;
    Valid = 1'b0;
    In_Mod_Data = 1'b0;
    Spread_Factor_Sel = 2'b00;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_out_data", Out_Data, 32'h0);
    chk("reset_valid_data", {31'd0, Valid_Data}, 32'h0);
    @(negedge Clk);
    N_Rst = 1'b1;

    // long idle with random data on the chip line
    clear_log();
    idle(1000);
    @(negedge Clk);
    chk("idle_pulses", pos_q.size(), 0);
    chk("idle_out_data", Out_Data, 32'h0);

    // beta=16 single word, Valid dropped right after completion
    Spread_Factor_Sel = 2'b11;
    clear_log();
    send_word(16, 32'hA5A5_3C3C);
    idle(3);
    chk("b16_pulses", pos_q.size(), 1);
    if (pos_q.size() == 1) begin
      chk("b16_pos", pos_q[0], 1024);
      chk("b16_word", word_q[0], 32'hA5A5_3C3C);
    end
    chk("b16_hold", Out_Data, 32'hA5A5_3C3C);

    // back-to-back words at beta 8, 4, 2
    for (int s = 2; s >= 0; s--) begin
      int b;
      b = 2 << s;
      Spread_Factor_Sel = 2'(s);
      clear_log();
      send_word(b, 32'hDEAD_BEEF);
      send_word(b, 32'hDEAD_BEEF);
      idle(3);
      chk($sformatf("b%0d_pulses", b), pos_q.size(), 2);
      if (pos_q.size() == 2) begin
        chk($sformatf("b%0d_pos0", b), pos_q[0], 64 * b);
        chk($sformatf("b%0d_pos1", b), pos_q[1], 128 * b);
        chk($sformatf("b%0d_word0", b), word_q[0], 32'hDEAD_BEEF);
        chk($sformatf("b%0d_word1", b), word_q[1], 32'hDEAD_BEEF);
      end
    end

    // beta=4: tie -> 0, 3 of 4 -> 1; select change mid-word must be ignored
    Spread_Factor_Sel = 2'b01;
    clear_log();
    send_frame(4, 2);
    Spread_Factor_Sel = 2'b11;
    send_frame(4, 3);
    send_frame(4, 1);
    for (int i = 3; i < 32; i++) send_frame(4, (32'hC3C3_C3C0 >> i) & 1 ? 4 : 0);
    idle(3);
    chk("tie_pulses", pos_q.size(), 1);
    if (pos_q.size() == 1) chk("tie_word", word_q[0], 32'hC3C3_C3C2);

    // beta=16: 10 frames, 1-cycle Valid drop, then a full word
    Spread_Factor_Sel = 2'b11;
    clear_log();
    for (int i = 0; i < 10; i++) send_frame(16, (i % 2) ? 16 : 0);
    idle(1);
    chk("drop_no_pulse", pos_q.size(), 0);
    clear_log();
    send_word(16, 32'h1234_5678);
    idle(3);
    chk("drop_pulses", pos_q.size(), 1);
    if (pos_q.size() == 1) begin
      chk("drop_pos", pos_q[0], 1024);
      chk("drop_word", word_q[0], 32'h1234_5678);
    end

    // beta=2: reset mid-word, then a full word
    Spread_Factor_Sel = 2'b00;
    clear_log();
    for (int i = 0; i < 20; i++) send_frame(2, 2);
    send_chip(1'b1);
    send_chip(1'b0);
    @(negedge Clk);
    N_Rst = 1'b0;
    Valid = 1'b0;
    #1;
    chk("rst_out_data", Out_Data, 32'h0);
    chk("rst_valid_data", {31'd0, Valid_Data}, 32'h0);
    repeat (2) @(negedge Clk);
    chk("rst_hold_out_data", Out_Data, 32'h0);
    N_Rst = 1'b1;
    chk("rst_no_pulse", pos_q.size(), 0);
    clear_log();
    send_word(2, 32'hFFFF_0000);
    idle(3);
    chk("rst_pulses", pos_q.size(), 1);
    if (pos_q.size() == 1) begin
      chk("rst_pos", pos_q[0], 128);
      chk("rst_word", word_q[0], 32'hFFFF_0000);
    end
    chk("rst_final_out", Out_Data, 32'hFFFF_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
